expu_result_collector: RTL
==========================

EXPU_RESULT_COLLECTOR -- requirements
Module: expu_result_collector

Interface
REQ-001 SHALL have parameter FPFORMAT, default fpnew_pkg::FP16ALT, the element format; WIDTH = fpnew_pkg::fp_width(FPFORMAT), 16 by default.
REQ-002 SHALL have parameter N_ROWS, default 1, the lanes per beat; N_ROWS >= 1.
REQ-003 SHALL have parameter DEPTH, default 4, the FIFO entries; power of two, >= 2.
REQ-004 SHALL have parameter LEN_WIDTH, default 16, the width of the beat counters.
REQ-005 clk_i  in  1  single clock, all state on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 clear_i  in  1  synchronous clear, same effect as reset.
REQ-008 enable_i  in  1  global enable; low freezes all state, forces ready_o=0 and valid_o=0.
REQ-009 start_i, len_i  in  1, LEN_WIDTH  start a job; len_i = number of beats to collect.
REQ-010 valid_i, strb_i, res_i  in  1, N_ROWS, N_ROWS x WIDTH  result beat from the exponential unit.
REQ-011 ready_o  out  1  ready toward the exponential unit.
REQ-012 valid_o, strb_o, data_o  out  1, N_ROWS, N_ROWS x WIDTH  downstream beat.
REQ-013 ready_i  in  1  downstream ready.
REQ-014 busy_o, done_o, count_o  out  1, 1, LEN_WIDTH  job active, one-cycle job-complete pulse, beats accepted so far.

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT, DRAIN, DONE; reset state IDLE.
REQ-016 IDLE: on start_i=1 and enable_i=1, SHALL latch len_i, zero count_o, go to COLLECT; if len_i=0, SHALL go to DONE directly.
REQ-017 start_i outside IDLE SHALL be ignored.
REQ-018 ready_o SHALL equal enable_i & (state==COLLECT) & ~full, with no combinational path from ready_i.
REQ-019 Push occurs when valid_i & ready_o; the FIFO SHALL store {strb_i, res_i} with each lane whose strb_i bit is 0 replaced by all-zero data.
REQ-020 Each push SHALL increment count_o by 1.
REQ-021 On the push that makes count_o equal the latched length, the FSM SHALL go to DRAIN next cycle; no further pushes are possible.
REQ-022 valid_o SHALL equal enable_i & ~empty, with data_o/strb_o taken from the FIFO head.
REQ-023 data_o and strb_o SHALL be all-zero while valid_o=0.
REQ-024 Pop occurs when valid_o & ready_i.
REQ-025 There SHALL be no fall-through: a pushed beat appears on valid_o the cycle after the push at the earliest.
REQ-026 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-027 When full, ready_o=0 even if a pop occurs in the same cycle.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit or occupancy counter.
REQ-029 DRAIN: when the FIFO is empty, SHALL go to DONE.
REQ-030 DONE: done_o=1 for exactly that cycle, then IDLE.
REQ-031 busy_o SHALL be 1 in COLLECT and DRAIN, 0 in IDLE and DONE.
REQ-032 count_o SHALL hold its final value until the next start.
REQ-033 enable_i=0 SHALL hold FSM, pointers, counters and done_o state unchanged.
REQ-034 Beat order SHALL be preserved end to end.

Reset
REQ-035 On rst_ni=0 (asynchronous) or clear_i=1 (synchronous), SHALL enter IDLE and empty the FIFO.
REQ-036 Reset/clear values: ready_o=0, valid_o=0, data_o=0, strb_o=0, busy_o=0, done_o=0, count_o=0.
REQ-037 Reset or clear during COLLECT or DRAIN SHALL discard buffered beats, with no done_o pulse.

Verification
REQ-038 DEPTH=4, N_ROWS=2, start len=3, valid_i every cycle, ready_i=1 -> three beats out in order, each one cycle after its push; count_o=3; done_o pulses once after the last pop.
REQ-039 len=6, ready_i=0 -> ready_o drops after 4 pushes; then ready_i=1 with simultaneous push/pop -> all 6 beats out in order, no loss or duplication.
REQ-040 strb_i=2'b01, res_i={16'h3F80,16'h4000} -> data_o lane1=16'h0000, lane0=16'h4000, strb_o=2'b01.
REQ-041 start with len_i=0 -> DONE the next cycle, done_o=1 for one cycle, ready_o never 1.
REQ-042 Reset asserted mid-COLLECT with 2 beats buffered -> all outputs 0 immediately; next start begins with an empty FIFO and count_o=0.
REQ-043 enable_i=0 for 3 cycles mid-job -> ready_o=0, valid_o=0, state and count_o frozen; resumes identically.

Source files
------------

// File: rtl/expu_result_collector.sv
// Result collector for the exponential unit: counts a job's beats,
// buffers them in a small FIFO and drains them downstream in order.

package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4,
    FP8ALT  = 3'd5
  } fp_format_e;

  function automatic int unsigned fp_width(fp_format_e fmt);
    int unsigned w;
    unique case (fmt)
      FP32:          w = 32;
      FP64:          w = 64;
      FP16, FP16ALT: w = 16;
      default:       w = 8;
    endcase
    return w;
  endfunction

endpackage

module expu_result_collector
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FPFORMAT  = FP16ALT,
  parameter int unsigned N_ROWS    = 1,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LEN_WIDTH = 16,
  localparam int unsigned WIDTH    = fp_width(FPFORMAT)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           enable_i,
  input  logic                           start_i,
  input  logic [LEN_WIDTH-1:0]           len_i,
  input  logic                           valid_i,
  input  logic [N_ROWS-1:0]              strb_i,
  input  logic [N_ROWS-1:0][WIDTH-1:0]   res_i,
  output logic                           ready_o,
  output logic                           valid_o,
  output logic [N_ROWS-1:0]              strb_o,
  output logic [N_ROWS-1:0][WIDTH-1:0]   data_o,
  input  logic                           ready_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [LEN_WIDTH-1:0]           count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] count_q;
  logic [LEN_WIDTH-1:0] count_inc;
  logic [AW:0]          wr_ptr_q;
  logic [AW:0]          rd_ptr_q;

  logic [N_ROWS-1:0]            strb_mem [DEPTH];
  logic [N_ROWS-1:0][WIDTH-1:0] data_mem [DEPTH];
  logic [N_ROWS-1:0][WIDTH-1:0] res_masked;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic start_ok;
  logic last_push;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign ready_o = enable_i & (state_q == COLLECT) & ~full;
  assign valid_o = enable_i & ~empty;
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  assign start_ok  = enable_i & start_i & (state_q == IDLE);
  assign count_inc = count_q + LEN_WIDTH'(1);
  assign last_push = push & (count_inc == len_q);
  assign count_o   = count_q;

  // State register; a low enable freezes the FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else if (clear_i) begin
      state_q <= IDLE;
    end else if (enable_i) begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = (len_i == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (last_push) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs and head-of-FIFO data, zeroed when nothing is valid.
  always_comb begin
    busy_o = (state_q == COLLECT) || (state_q == DRAIN);
    done_o = (state_q == DONE);
    strb_o = '0;
    data_o = '0;
    if (valid_o) begin
      strb_o = strb_mem[rd_ptr_q[AW-1:0]];
      data_o = data_mem[rd_ptr_q[AW-1:0]];
    end
  end

  // Lanes with a cleared strobe are stored as zero.
  always_comb begin
    res_masked = '0;
    for (int unsigned r = 0; r < N_ROWS; r++) begin
      res_masked[r] = strb_i[r] ? res_i[r] : '0;
    end
  end

  // FIFO pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage, written on push only.
  always_ff @(posedge clk_i) begin
    if (push) begin
      strb_mem[wr_ptr_q[AW-1:0]] <= strb_i;
      data_mem[wr_ptr_q[AW-1:0]] <= res_masked;
    end
  end

  // Job length latch and accepted-beat counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q   <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      len_q   <= '0;
      count_q <= '0;
    end else if (start_ok) begin
      len_q   <= len_i;
      count_q <= '0;
    end else if (push) begin
      count_q <= count_inc;
    end
  end

endmodule
